// File: rtl/kyo_palette_arbiter.sv
// kyo_palette_arbiter
//   Shares one combinational palette ROM between two sprite renderers.
//   A round-robin arbiter grants at most one request per cycle. The granted
//   index is registered onto pal_index (stage 1). The ROM colour is registered
//   one cycle later together with owner and colour-key flag (stage 2), so the
//   latency is fixed at 2 cycles and the throughput is one lookup per cycle.
//
// Ports
//   Clk, Reset                   clock, async active-high reset
//   p1_req, p1_index             player-1 lookup request and palette index
//   p2_req, p2_index             player-2 lookup request and palette index
//   p1_gnt, p2_gnt               combinational grants
//   pal_index                    registered index to the palette ROM
//   pal_red, pal_green, pal_blue ROM colour for pal_index (same cycle)
//   red, green, blue             registered lookup result
//   rgb_valid                    result registers hold a new result
//   rgb_owner                    0 = player 1, 1 = player 2
//   transparent                  result index equals TRANSPARENT_IDX
module kyo_palette_arbiter #(
   parameter logic [3:0] TRANSPARENT_IDX = 4'hF
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       p1_req,
   input  logic [3:0] p1_index,
   input  logic       p2_req,
   input  logic [3:0] p2_index,
   output logic       p1_gnt,
   output logic       p2_gnt,
   output logic [3:0] pal_index,
   input  logic [3:0] pal_red,
   input  logic [3:0] pal_green,
   input  logic [3:0] pal_blue,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       rgb_valid,
   output logic       rgb_owner,
   output logic       transparent
);

   // 0 = player 1 was granted last, 1 = player 2. Resets to 1 so player 1
   // wins the first tie.
   logic       last_owner;
   logic       s1_valid;
   logic       s1_owner;
   logic [3:0] s1_index;

   // p1 wins when alone or when p2 was granted last; otherwise p2 takes any
   // remaining request.
   always_comb begin
      p1_gnt = 1'b0;
      p2_gnt = 1'b0;
      if (!Reset) begin
         if (p1_req && (!p2_req || last_owner)) begin
            p1_gnt = 1'b1;
         end else if (p2_req) begin
            p2_gnt = 1'b1;
         end
      end
   end

   // Stage 1: capture the granted request and present its index to the ROM.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pal_index  <= 4'h0;
         s1_valid   <= 1'b0;
         s1_owner   <= 1'b0;
         s1_index   <= 4'h0;
         last_owner <= 1'b1;
      end else begin
         s1_valid <= p1_gnt | p2_gnt;
         if (p1_gnt) begin
            pal_index  <= p1_index;
            s1_index   <= p1_index;
            s1_owner   <= 1'b0;
            last_owner <= 1'b0;
         end else if (p2_gnt) begin
            pal_index  <= p2_index;
            s1_index   <= p2_index;
            s1_owner   <= 1'b1;
            last_owner <= 1'b1;
         end
      end
   end

   // Stage 2: register the ROM colour; result fields hold while idle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         red         <= 4'h0;
         green       <= 4'h0;
         blue        <= 4'h0;
         rgb_valid   <= 1'b0;
         rgb_owner   <= 1'b0;
         transparent <= 1'b0;
      end else begin
         rgb_valid <= s1_valid;
         if (s1_valid) begin
            red         <= pal_red;
            green       <= pal_green;
            blue        <= pal_blue;
            rgb_owner   <= s1_owner;
            transparent <= (s1_index == TRANSPARENT_IDX);
         end
      end
   end

endmodule
